// File: rtl/riscv_boot_pkg.sv
// riscv_boot_pkg: shared states and constants for the boot/run sequencer
package riscv_boot_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;
  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;
  localparam int LEN_W = 16;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs a little-endian byte stream into 32-bit words with a registered word strobe
module byte_packer
  import riscv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  lane
);
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        vld_q, vld_d;
  always_comb begin
    lane_d = clr ? 2'd0 : in_valid ? lane_q + 2'd1 : lane_q;
    word_d = clr ? '0 : in_valid ? {in_data, word_q[31:8]} : word_q;
    vld_d  = !clr && in_valid && lane_q == 2'(BYTES_PER_WORD - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end
  assign word_valid = vld_q;
  assign word       = word_q;
  assign lane       = lane_q;
endmodule

// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: loads a byte-stream image into IMEM, runs the core until ecall or watchdog
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_run,
  input  logic [31:0]       cpu_instr,
  input  logic [31:0]       cpu_a0,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [31:0]       result,
  output logic [31:0]       cycles
);
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, n;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       result_q, result_d, cycles_q, cycles_d;
  logic              start_ok, accept, is_ecall, last_word, word_valid;
  logic [31:0]       word;
  logic [1:0]        lane;
  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .in_valid   (accept && state_q == S_LOAD),
    .in_data    (s_data),
    .word_valid (word_valid),
    .word       (word),
    .lane       (lane)
  );
  always_comb begin
    start_ok    = start && (state_q inside {S_IDLE, S_HALT, S_ERR});
    accept      = s_valid && s_ready_q;
    is_ecall    = cpu_instr == ECALL_INSN;
    n           = {s_data, len_q[7:0]};
    last_word   = 32'(widx_q) == 32'(len_q) - 32'd1;
    state_d     = state_q;
    len_d       = len_q;
    cpu_rst_n_d = cpu_rst_n_q;
    timeout_d   = timeout_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    widx_d      = start_ok ? '0 : word_valid ? widx_q + ADDR_W'(1) : widx_q;
    if (start_ok) begin
      state_d     = S_LEN_LO;
      cycles_d    = '0;
      timeout_d   = 1'b0;
      cpu_rst_n_d = 1'b0;
    end else begin
      case (state_q)
        S_LEN_LO: if (accept) begin
          len_d   = {8'h00, s_data};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          len_d   = n;
          state_d = (n == '0 || 32'(n) > (32'd1 << ADDR_W)) ? S_ERR : S_LOAD;
        end
        S_LOAD: if (accept && lane == 2'(BYTES_PER_WORD - 1) && last_word) state_d = S_FLUSH;
        S_FLUSH: begin
          state_d     = S_RUN;
          cpu_rst_n_d = 1'b1;
        end
        S_RUN: if (is_ecall) begin
          state_d  = S_HALT;
          result_d = cpu_a0;
        end else begin
          cycles_d = cycles_q + 32'd1;
          if (cycles_q == 32'(MAX_CYCLES - 1)) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    s_ready_d = state_d inside {S_LEN_LO, S_LEN_HI, S_LOAD};
    busy_d    = state_d inside {S_LEN_LO, S_LEN_HI, S_LOAD, S_FLUSH, S_RUN};
    done_d    = state_d == S_HALT;
    err_d     = state_d == S_ERR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      widx_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      result_q    <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
    end
  end
  assign cpu_run    = state_q == S_RUN && !is_ecall;
  assign s_ready    = s_ready_q;
  assign imem_we    = word_valid;
  assign imem_waddr = widx_q;
  assign imem_wdata = word;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign timeout    = timeout_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// tb_riscv_boot_ctrl: directed load/run/halt/error scenarios against a tiny core model
module tb_riscv_boot_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, imem_we, cpu_rst_n, cpu_run, busy, done, err, timeout;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata, cpu_instr, cpu_a0, result, cycles;
  logic [31:0] tmem [0:255];
  logic [7:0]  pc;
  logic [31:0] prog [$];
  int          n_checks = 0, n_fail = 0, runs;
  always #5 clk = ~clk;
  riscv_boot_ctrl #(.ADDR_W(8), .MAX_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .cpu_run(cpu_run), .cpu_instr(cpu_instr), .cpu_a0(cpu_a0),
    .busy(busy), .done(done), .err(err), .timeout(timeout), .result(result), .cycles(cycles)
  );
  always @(posedge clk) if (imem_we) tmem[imem_waddr] <= imem_wdata;
  always @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pc     <= '0;
      cpu_a0 <= '0;
    end else if (cpu_run) begin
      pc <= (cpu_instr[6:0] == 7'h6F) ? pc : pc + 8'd1;
      if (cpu_instr[6:0] == 7'h13 && cpu_instr[11:7] == 5'd10)
        cpu_a0 <= {{20{cpu_instr[31]}}, cpu_instr[31:20]};
    end
  end
  assign cpu_instr = tmem[pc];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    check("s_ready_before_send", s_ready, 1);
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask
  task automatic idle(input int gap);
    repeat (gap) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("we_in_gap", imem_we, 0);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic load_prog(input int gap);
    int n = prog.size();
    send(8'(n));
    idle(gap);
    send(8'(n >> 8));
    idle(gap);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        send(prog[w][8*b +: 8]);
        if (b == 3) begin
          check("imem_we", imem_we, 1);
          check("imem_waddr", imem_waddr, w);
          check("imem_wdata", imem_wdata, prog[w]);
        end
        if (!(w == n - 1 && b == 3)) idle(gap);
      end
    end
    check("flush_busy", busy, 1);
    check("flush_cpu_rst_n", cpu_rst_n, 0);
    check("flush_cpu_run", cpu_run, 0);
    @(negedge clk);
    check("run_cpu_rst_n", cpu_rst_n, 1);
    check("run_s_ready", s_ready, 0);
  endtask
  task automatic run_until_stop(output int r);
    r = 0;
    for (int i = 0; i < 100 && !(done || err); i++) begin
      if (cpu_run) r++;
      @(negedge clk);
    end
    check("stopped_in_budget", done | err, 1);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_waddr"}, imem_waddr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_cycles"}, cycles, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    check("lenlo_s_ready", s_ready, 1);
    check("lenlo_busy", busy, 1);
    prog = '{32'h00500513, 32'h00A00593, 32'h00000073};
    load_prog(0);
    check("run_cpu_run", cpu_run, 1);
    run_until_stop(runs);
    check("p1_done", done, 1);
    check("p1_result", result, 5);
    check("p1_cycles", cycles, 2);
    check("p1_runs", runs, 2);
    check("p1_halt_cpu_run", cpu_run, 0);
    check("p1_halt_cpu_rst_n", cpu_rst_n, 1);
    check("p1_tmem2", tmem[2], 32'h00000073);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    @(negedge clk);
    check("halt_s_ready", s_ready, 0);
    s_valid = 1'b0;
    pulse_start();
    check("restart_done", done, 0);
    check("restart_cpu_rst_n", cpu_rst_n, 0);
    check("restart_s_ready", s_ready, 1);
    prog = '{32'h00700513, 32'h00000073};
    load_prog(1);
    run_until_stop(runs);
    check("p2_result", result, 7);
    check("p2_cycles", cycles, 1);
    check("p2_tmem0", tmem[0], 32'h00700513);
    check("p2_tmem1", tmem[1], 32'h00000073);
    pulse_start();
    send(8'h00);
    send(8'h00);
    check("n0_err", err, 1);
    check("n0_timeout", timeout, 0);
    check("n0_s_ready", s_ready, 0);
    check("n0_we", imem_we, 0);
    pulse_start();
    send(8'h01);
    send(8'h01);
    check("n257_err", err, 1);
    check("n257_timeout", timeout, 0);
    check("n257_s_ready", s_ready, 0);
    check("n257_we", imem_we, 0);
    pulse_start();
    prog = '{32'h0000006F};
    load_prog(0);
    run_until_stop(runs);
    check("wd_err", err, 1);
    check("wd_timeout", timeout, 1);
    check("wd_cycles", cycles, 16);
    check("wd_runs", runs, 16);
    check("wd_cpu_run", cpu_run, 0);
    check("wd_done", done, 0);
    pulse_start();
    check("start_clears_timeout", timeout, 0);
    send(8'h02);
    send(8'h00);
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    check("pre_rst_we", imem_we, 1);
    send(8'h11);
    send(8'h22);
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    prog = '{32'h00500513};
    load_prog(0);
    run_until_stop(runs);
    check("p3_done", done, 1);
    check("p3_result", result, 5);
    check("p3_cycles", cycles, 1);
    check("p3_tmem0", tmem[0], 32'h00500513);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_boot_ctrl.md
# riscv_boot_ctrl

Boot and run sequencer for the single-cycle RV32I core. It receives a program image as a byte stream and writes it word-by-word into instruction memory while holding the core in reset. It then releases the core, gates its execution with a clock enable, and detects `ecall` to halt. It captures x10 (a0) as the run result and enforces a cycle-budget watchdog. It sits between the host/UART byte source and the core's IMEM write port, reset and enable inputs.

## Interface
Parameters:
- `ADDR_W`, 8: IMEM word-address width; depth = 2**ADDR_W words.
- `MAX_CYCLES`, 100000: run-cycle budget before timeout.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a load, honoured in IDLE/HALT/ERR only.
- `s_valid`  in  1  byte-stream valid.
- `s_data`  in  8  byte-stream data.
- `s_ready`  out  1  byte-stream ready.
- `imem_we`  out  1  IMEM write enable.
- `imem_waddr`  out  ADDR_W  IMEM word address.
- `imem_wdata`  out  32  IMEM write data.
- `cpu_rst_n`  out  1  core reset, active-low.
- `cpu_run`  out  1  core clock enable; PC and register file update only when high.
- `cpu_instr`  in  32  instruction currently fetched by the core.
- `cpu_a0`  in  32  core x10 monitor.
- `busy`  out  1  high in LEN_LO, LEN_HI, LOAD, FLUSH and RUN.
- `done`  out  1  high in HALT.
- `err`  out  1  high in ERR.
- `timeout`  out  1  ERR was entered via the watchdog; cleared by `start`.
- `result`  out  32  a0 captured at halt.
- `cycles`  out  32  count of RUN cycles with `cpu_run`=1.

## Operation
- States: IDLE, LEN_LO, LEN_HI, LOAD, FLUSH, RUN, HALT, ERR.
- IDLE/HALT/ERR + `start` → LEN_LO. On the `start` edge:
  - clear `cycles`, `timeout`, word index and byte lane;
  - `cpu_rst_n` goes low.
- A byte is accepted on any edge with `s_valid & s_ready`. `s_ready`=1 only in LEN_LO, LEN_HI and LOAD.
- LEN_LO: the accepted byte is N[7:0]; go to LEN_HI.
- LEN_HI: the accepted byte is N[15:8], where N is the 16-bit word count.
  - If N==0 or N>2**ADDR_W, go to ERR (`timeout`=0).
  - Otherwise go to LOAD.
- LOAD: bytes pack little-endian (first byte → [7:0]).
  - On the 4th byte of a word, the registered write is issued next cycle: `imem_we`=1, `imem_waddr`=word index, `imem_wdata`=packed word. The index then increments.
  - On the 4th byte of word N−1, go to FLUSH instead of staying in LOAD.
- FLUSH: exactly one cycle, carrying the final `imem_we`. Then go to RUN with `cpu_rst_n`=1.
- RUN:
  - `cpu_run` = (state==RUN) && (`cpu_instr` != 32'h0000_0073). This is combinational, so the `ecall` itself never retires.
  - On an edge with `cpu_instr`==ecall: go to HALT and `result` <= `cpu_a0`.
  - Otherwise `cycles` increments on each edge. When `cycles` reaches MAX_CYCLES−1 with `cpu_run` high, go to ERR with `timeout`=1.
  - If ecall and the budget limit coincide on the same edge, ecall wins (HALT).
- HALT/ERR: `cpu_run`=0 and `cpu_rst_n` stays 1, so core state remains observable. Wait for `start`.
- `start` outside IDLE/HALT/ERR is ignored.
- `s_valid` while `s_ready`=0 is not consumed.

## Timing
- Reset values: state IDLE, all outputs 0 (`s_ready`, `imem_*`, `cpu_rst_n`, `cpu_run`, `busy`, `done`, `err`, `timeout`, `result`, `cycles`), and byte lane 0.
- Reset mid-load or mid-run aborts immediately with no partial-word write. `cpu_rst_n` falls asynchronously with `rst_n`.
- Byte throughput is 1 per cycle, with no bubbles between words.
- Write latency: 4th byte accepted at edge k → `imem_we` high during cycle k+1 → memory updated at edge k+1.
- Last word: 4th byte at edge k; FLUSH in cycle k+1; RUN from cycle k+2. The core fetches PC 0 in cycle k+2, after every word has been written.
- ecall seen in cycle m: HALT from cycle m+1, with `result` valid and `done`=1 in cycle m+1.
- All outputs except `cpu_run` are registered.

## Structure
- Package `riscv_boot_pkg`:
  - state enum;
  - `ECALL_INSN` = 32'h0000_0073;
  - `LEN_W` = 16;
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer`:
  - 2-bit lane counter and 32-bit shift/assemble register;
  - outputs `word_valid` and `word`;
  - synchronous clear on `start`.
- The FSM, counters and watchdog live in the top module.

## Test plan
- Load N=3, bytes 13 05 50 00 | 93 05 A0 00 | 73 00 00 00 → writes at addrs 0, 1, 2 with data 0x00500513, 0x00A00593, 0x00000073, each one cycle after its 4th byte. RUN starts 2 cycles after the last byte. Expect HALT with `result`=5 and `cycles`=2.
- `s_valid` toggling 1/0 every cycle during LOAD → identical IMEM contents; no byte lost or duplicated.
- Length N=0, then separately N=257 with ADDR_W=8 → ERR after the LEN_HI byte; `timeout`=0, `s_ready`=0, no `imem_we`.
- Program `jal x0,0` (0x0000006F) with MAX_CYCLES=16 → ERR with `timeout`=1 after 16 run cycles; `cpu_run` falls in that cycle.
- `rst_n` asserted after 2 bytes of word 1 → all outputs 0 immediately. Reload N=1 → word written at addr 0, byte lane restarted.
- `start` pulsed in HALT → `done` clears, `cpu_rst_n` goes low next cycle, state LEN_LO. A second image loads and runs correctly.
